// File: rtl/read_exec_pipe_reg_if.sv
// Read-to-Execute pipeline bus: upstream handshake and payload in, head entry out.
// master = Read/Execute environment side, slave = the pipeline register.
interface read_exec_pipe_reg_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned CTRL_W = 256
);
  logic              inValidIn;
  logic              inReadyOut;
  logic [DATA_W-1:0] op1In;
  logic [DATA_W-1:0] op2In;
  logic              op1ValidIn;
  logic              op2ValidIn;
  logic [REG_W-1:0]  src1In;
  logic [REG_W-1:0]  src2In;
  logic [REG_W-1:0]  destRegIn;
  logic [DATA_W-1:0] destValIn;
  logic [CTRL_W-1:0] ctrlIn;

  logic              outValidOut;
  logic              outReadyIn;
  logic [DATA_W-1:0] op1Out;
  logic [DATA_W-1:0] op2Out;
  logic              op1ValidOut;
  logic              op2ValidOut;
  logic [REG_W-1:0]  src1Out;
  logic [REG_W-1:0]  src2Out;
  logic [REG_W-1:0]  destRegOut;
  logic [DATA_W-1:0] destValOut;
  logic [CTRL_W-1:0] ctrlOut;

  modport master (
    output inValidIn, op1In, op2In, op1ValidIn, op2ValidIn, src1In, src2In, destRegIn,
           destValIn, ctrlIn, outReadyIn,
    input  inReadyOut, outValidOut, op1Out, op2Out, op1ValidOut, op2ValidOut, src1Out,
           src2Out, destRegOut, destValOut, ctrlOut
  );

  modport slave (
    input  inValidIn, op1In, op2In, op1ValidIn, op2ValidIn, src1In, src2In, destRegIn,
           destValIn, ctrlIn, outReadyIn,
    output inReadyOut, outValidOut, op1Out, op2Out, op1ValidOut, op2ValidOut, src1Out,
           src2Out, destRegOut, destValOut, ctrlOut
  );
endinterface

// File: rtl/read_exec_pipe_reg.sv
// Read->Execute pipeline register: 2-entry skid buffer with flush and saturating stall counter.
// Define RD_EX_FORWARDING_EN to patch buffered operands/destVal from the writeback port.
module read_exec_pipe_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned CTRL_W = 256,
  parameter int unsigned DEPTH  = 2
) (
  input  logic               clk,
  input  logic               resetN,
  read_exec_pipe_reg_if.slave bus,
  input  logic               flushIn,
  input  logic               wbValidIn,
  input  logic [REG_W-1:0]   wbRegIn,
  input  logic [DATA_W-1:0]  wbDataIn,
  output logic [31:0]        stallCountOut
);

  if (DEPTH != 2) begin : gDepthCheck
    $error("read_exec_pipe_reg: DEPTH must be 2");
  end

  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              op1Valid;
    logic              op2Valid;
    logic [REG_W-1:0]  src1;
    logic [REG_W-1:0]  src2;
    logic [REG_W-1:0]  destReg;
    logic [DATA_W-1:0] destVal;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t      slotQ [2];
  entry_t      slotD [2];
  logic        headQ, headD;
  logic [1:0]  countQ, countD;
  logic [31:0] stallCntQ, stallCntD;

  logic   push, pop, tailIdx;
  entry_t inEntry, headEntry;

  // Handshake depends only on registered count, so no comb path from outReadyIn to inReadyOut.
  assign bus.outValidOut = (countQ != 2'd0);
  assign bus.inReadyOut  = (countQ != 2'd2);

  assign push    = bus.inValidIn & bus.inReadyOut;
  assign pop     = bus.outValidOut & bus.outReadyIn;
  assign tailIdx = headQ ^ countQ[0];

  assign inEntry = '{
    op1:      bus.op1In,
    op2:      bus.op2In,
    op1Valid: bus.op1ValidIn,
    op2Valid: bus.op2ValidIn,
    src1:     bus.src1In,
    src2:     bus.src2In,
    destReg:  bus.destRegIn,
    destVal:  bus.destValIn,
    ctrl:     bus.ctrlIn
  };

`ifdef RD_EX_FORWARDING_EN
  logic [1:0] slotLive;
  always_comb begin
    slotLive = 2'b00;
    for (int i = 0; i < 2; i++) begin
      slotLive[i] = (countQ == 2'd2) || ((countQ == 2'd1) && (headQ == 1'(i))) ||
                    (push && (tailIdx == 1'(i)));
    end
  end
`else
  logic unusedWb;
  assign unusedWb = ^{wbValidIn, wbRegIn, wbDataIn};
`endif

  always_comb begin
    slotD  = slotQ;
    headD  = headQ;
    countD = countQ;
    if (flushIn) begin
      // A same-cycle pop is still taken by Execute; nothing else survives.
      countD = 2'd0;
    end else begin
      if (push) slotD[tailIdx] = inEntry;
      if (pop)  headD = ~headQ;
      countD = countQ + {1'b0, push} - {1'b0, pop};
`ifdef RD_EX_FORWARDING_EN
      // Applied after the push write so a forwarded value beats the pushed one.
      for (int i = 0; i < 2; i++) begin
        if (slotLive[i] && wbValidIn) begin
          if (slotD[i].op1Valid && (slotD[i].src1 == wbRegIn)) slotD[i].op1 = wbDataIn;
          if (slotD[i].op2Valid && (slotD[i].src2 == wbRegIn)) slotD[i].op2 = wbDataIn;
          if (slotD[i].destReg == wbRegIn) slotD[i].destVal = wbDataIn;
        end
      end
`endif
    end
  end

  always_comb begin
    stallCntD = stallCntQ;
    if (bus.outValidOut && !bus.outReadyIn && !flushIn && (stallCntQ != 32'hFFFF_FFFF)) begin
      stallCntD = stallCntQ + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      headQ     <= 1'b0;
      countQ    <= 2'd0;
      stallCntQ <= 32'd0;
      for (int i = 0; i < 2; i++) slotQ[i] <= '0;
    end else begin
      headQ     <= headD;
      countQ    <= countD;
      stallCntQ <= stallCntD;
      for (int i = 0; i < 2; i++) slotQ[i] <= slotD[i];
    end
  end

  assign headEntry       = slotQ[headQ];
  assign bus.op1Out      = headEntry.op1;
  assign bus.op2Out      = headEntry.op2;
  assign bus.op1ValidOut = headEntry.op1Valid;
  assign bus.op2ValidOut = headEntry.op2Valid;
  assign bus.src1Out     = headEntry.src1;
  assign bus.src2Out     = headEntry.src2;
  assign bus.destRegOut  = headEntry.destReg;
  assign bus.destValOut  = headEntry.destVal;
  assign bus.ctrlOut     = headEntry.ctrl;
  assign stallCountOut   = stallCntQ;

endmodule

// File: tb/tb_read_exec_pipe_reg.sv
// Directed bench for read_exec_pipe_reg: vector table plus reset, forwarding and saturation
// sequences. Forwarding expectations follow RD_EX_FORWARDING_EN.
module tb_read_exec_pipe_reg;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned CTRL_W = 256;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic              clk;
  logic              resetN;
  logic              flushIn;
  logic              wbValidIn;
  logic [REG_W-1:0]  wbRegIn;
  logic [DATA_W-1:0] wbDataIn;
  logic [31:0]       stallCountOut;

  int checks   = 0;
  int failures = 0;

  read_exec_pipe_reg_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)) ifc ();

  read_exec_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W), .DEPTH(2)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .bus           (ifc.slave),
    .flushIn       (flushIn),
    .wbValidIn     (wbValidIn),
    .wbRegIn       (wbRegIn),
    .wbDataIn      (wbDataIn),
    .stallCountOut (stallCountOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        inV;
    bit        outR;
    bit        fl;
    bit [7:0]  op;
    bit        eV;
    bit        eR;
    bit [7:0]  eOp;
    bit [31:0] eStall;
  } vec_t;

  vec_t vecs[$];

  task automatic addV(input bit inV, input bit outR, input bit fl, input bit [7:0] op,
                      input bit eV, input bit eR, input bit [7:0] eOp, input bit [31:0] eSt);
    vec_t v;
    v.inV = inV; v.outR = outR; v.fl = fl; v.op = op;
    v.eV = eV; v.eR = eR; v.eOp = eOp; v.eStall = eSt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Payload fields are all derived from the op byte so the head entry is fully identifiable.
  task automatic drive(input bit inV, input bit [7:0] op, input bit outR, input bit fl);
    ifc.inValidIn  = inV;
    ifc.op1In      = 64'(op);
    ifc.op2In      = 64'(op) + 64'h100;
    ifc.op1ValidIn = 1'b1;
    ifc.op2ValidIn = op[0];
    ifc.src1In     = op[3:0];
    ifc.src2In     = ~op[3:0];
    ifc.destRegIn  = op[7:4];
    ifc.destValIn  = 64'(op) ^ 64'hFFFF;
    ifc.ctrlIn     = {192'd0, 64'(op) * 64'd3};
    ifc.outReadyIn = outR;
    flushIn        = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetN    = 1'b0;
    wbValidIn = 1'b0;
    wbRegIn   = '0;
    wbDataIn  = '0;
    drive(L, 8'h00, L, L);

    // Back-pressure: A, B held, extra push refused, then drained in order.
    addV(H, L, L, 8'h0A, H, H, 8'h0A, 32'd0);
    addV(H, L, L, 8'h0B, H, L, 8'h0A, 32'd1);
    addV(H, L, L, 8'h0C, H, L, 8'h0A, 32'd2);
    addV(L, H, L, 8'h00, H, H, 8'h0B, 32'd2);
    addV(L, H, L, 8'h00, L, H, 8'h00, 32'd2);
    // Streaming 0..9 with push+pop every cycle.
    for (int k = 0; k < 10; k++) addV(H, H, L, 8'(k), H, H, 8'(k), 32'd2);
    addV(L, H, L, 8'h00, L, H, 8'h00, 32'd2);
    // Flush with a full buffer and a concurrent push of 0x22.
    addV(H, L, L, 8'h20, H, H, 8'h20, 32'd2);
    addV(H, L, L, 8'h21, H, L, 8'h20, 32'd3);
    addV(H, L, H, 8'h22, L, H, 8'h00, 32'd3);
    addV(L, H, L, 8'h00, L, H, 8'h00, 32'd3);
    addV(H, H, L, 8'h30, H, H, 8'h30, 32'd3);
    addV(L, H, L, 8'h00, L, H, 8'h00, 32'd3);

    repeat (2) @(posedge clk);
    #1;
    check("reset_outValid", 64'(ifc.outValidOut), 64'd0);
    check("reset_inReady", 64'(ifc.inReadyOut), 64'd1);
    check("reset_stall", 64'(stallCountOut), 64'd0);
    check("reset_op1", ifc.op1Out, 64'd0);
    check("reset_ctrl", ifc.ctrlOut[63:0], 64'd0);
    @(negedge clk);
    resetN = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].inV, vecs[i].op, vecs[i].outR, vecs[i].fl);
      step();
      check($sformatf("vec%0d_outValid", i), 64'(ifc.outValidOut), 64'(vecs[i].eV));
      check($sformatf("vec%0d_inReady", i), 64'(ifc.inReadyOut), 64'(vecs[i].eR));
      check($sformatf("vec%0d_stall", i), 64'(stallCountOut), 64'(vecs[i].eStall));
      if (vecs[i].eV) begin
        check($sformatf("vec%0d_op1", i), ifc.op1Out, 64'(vecs[i].eOp));
        check($sformatf("vec%0d_op2", i), ifc.op2Out, 64'(vecs[i].eOp) + 64'h100);
        check($sformatf("vec%0d_ctrl", i), ifc.ctrlOut[63:0], 64'(vecs[i].eOp) * 64'd3);
      end
    end

    // Forwarding onto a buffered entry (src1=3, op1=0x11).
    drive(H, 8'h11, L, L);
    ifc.src1In = 4'd3;
    step();
    check("fwd_buffered_before", ifc.op1Out, 64'h11);
    drive(L, 8'h00, L, L);
    wbValidIn = 1'b1; wbRegIn = 4'd3; wbDataIn = 64'hAB;
    step();
`ifdef RD_EX_FORWARDING_EN
    check("fwd_buffered_op1", ifc.op1Out, 64'hAB);
`else
    check("fwd_buffered_op1", ifc.op1Out, 64'h11);
`endif
    wbValidIn = 1'b0;
    drive(L, 8'h00, H, L);
    step();
    check("fwd_drain_outValid", 64'(ifc.outValidOut), 64'd0);
    // Forwarding onto the entry being pushed (op 0x13 -> src1=3).
    drive(H, 8'h13, L, L);
    wbValidIn = 1'b1; wbRegIn = 4'd3; wbDataIn = 64'hCD;
    step();
`ifdef RD_EX_FORWARDING_EN
    check("fwd_push_op1", ifc.op1Out, 64'hCD);
`else
    check("fwd_push_op1", ifc.op1Out, 64'h13);
`endif
    wbValidIn = 1'b0;
    drive(L, 8'h00, H, L);
    step();
    check("fwd_push_drain", 64'(ifc.outValidOut), 64'd0);

    // Saturation from a preloaded counter.
    drive(H, 8'h40, L, L);
    step();
    drive(L, 8'h00, L, L);
    force dut.stallCntQ = 32'hFFFF_FFFE;
    #1;
    release dut.stallCntQ;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("sat_cycle%0d", c), 64'(stallCountOut), 64'hFFFF_FFFF);
    end

    // Reset mid-traffic with a full buffer.
    drive(L, 8'h00, H, L);
    step();
    drive(H, 8'h50, L, L);
    step();
    drive(H, 8'h51, L, L);
    step();
    check("full_inReady", 64'(ifc.inReadyOut), 64'd0);
    drive(L, 8'h00, L, L);
    resetN = 1'b0;
    #1;
    check("async_reset_outValid", 64'(ifc.outValidOut), 64'd0);
    check("async_reset_inReady", 64'(ifc.inReadyOut), 64'd1);
    check("async_reset_stall", 64'(stallCountOut), 64'd0);
    step();
    check("held_reset_op1", ifc.op1Out, 64'd0);
    check("held_reset_outValid", 64'(ifc.outValidOut), 64'd0);
    @(negedge clk);
    resetN = 1'b1;
    step();
    check("post_reset_idle", 64'(ifc.outValidOut), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
